// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the load/store path. One transaction is outstanding at a time; data
// has priority, with a starvation counter that forces a fetch grant after
// IF_STARVE_MAX consecutive data grants while a fetch is waiting.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (addr[1:0] forced to 0)
//   if_ack/if_rdata/if_err        fetch response (one-cycle ack pulse)
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request
//   d_ack/d_rdata/d_err           load/store response (one-cycle ack pulse)
//   mem_valid/mem_we/mem_be/mem_addr/mem_wdata  memory request, held to ready
//   mem_ready/mem_rdata           memory completion
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a watchdog that aborts
// a memory access after TIMEOUT_CYCLES cycles without mem_ready (ack with err=1).
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned IF_STARVE_MAX  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned SC_W = $clog2(IF_STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_IF = 2'd1,
        MEM_D  = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q;
    logic [SC_W-1:0]   starve_q;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              grant_d_c;

    // Data wins unless the fetch has already been passed over IF_STARVE_MAX times.
    assign grant_d_c = d_req && (!if_req || (starve_q != SC_W'(IF_STARVE_MAX)));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             if_err_q;
    logic             d_err_q;
    logic             tmo_hit_c;

    // Last waiting cycle: mem_valid has now been high for TIMEOUT_CYCLES cycles.
    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign if_err    = if_err_q;
    assign d_err     = d_err_q;
`else
    logic unused_c;

    assign if_err   = 1'b0;
    assign d_err    = 1'b0;
    assign unused_c = ^{32'(TIMEOUT_CYCLES)};
`endif

    logic unused_addr_c;
    assign unused_addr_c = ^if_addr[1:0];

    // Arbitration FSM with registered memory request and responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q       <= '0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_q <= '0;
`endif
                    if (grant_d_c) begin
                        state_q     <= MEM_D;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_be_q    <= d_be;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        // Count only grants that made a waiting fetch wait longer.
                        if (if_req) begin
                            if (starve_q != SC_W'(IF_STARVE_MAX)) begin
                                starve_q <= starve_q + SC_W'(1);
                            end
                        end else begin
                            starve_q <= '0;
                        end
                    end else if (if_req) begin
                        state_q     <= MEM_IF;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= 4'b1111;
                        mem_addr_q  <= {if_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_q <= '0;
                        starve_q    <= '0;
                    end
                end
                MEM_IF, MEM_D: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= RESP;
                        if (state_q == MEM_IF) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_rdata;
                        end else begin
                            d_ack_q    <= 1'b1;
                            d_rdata_q  <= mem_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // Abort: fetch sees a NOP, data sees zero, both flagged err.
                    else if (tmo_hit_c) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= RESP;
                        if (state_q == MEM_IF) begin
                            if_ack_q   <= 1'b1;
                            if_err_q   <= 1'b1;
                            if_rdata_q <= 32'h0000_0013;
                        end else begin
                            d_ack_q    <= 1'b1;
                            d_err_q    <= 1'b1;
                            d_rdata_q  <= 32'h0000_0000;
                        end
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                RESP: begin
                    // Requests are ignored here so a still-high req is not re-granted.
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    if_err_q <= 1'b0;
                    d_err_q  <= 1'b0;
`endif
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned SMAX = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 64;
`endif

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;
    logic          if_err;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic          mem_valid;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    mem_port_arbiter #(
        .ADDR_W        (AW),
        .IF_STARVE_MAX (SMAX),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Requester queues and stimulus controls
    logic [31:0] if_q[$];
    dreq_t       d_q[$];
    bit          rand_mode    = 0;
    int          rst_cycles   = 0;
    int          mem_wait_cfg = -1;
    bit          mem_data_fix = 0;
    logic [31:0] mem_data_val = '0;
    bit          spurious_en  = 0;
    bit          mbusy        = 0;
    int          mwait        = 0;

    // Observations of the DUT for directed checks
    bit          ack_log[$];
    int          vcycles   = 0;
    int          hs_cycle  = 0;
    int          ack_cycle = 0;
    logic [31:0] obs_addr  = '0;
    logic [31:0] obs_wdata = '0;
    logic [3:0]  obs_be    = '0;
    logic        obs_we    = 1'b0;
    logic        obs_err   = 1'b0;

    // Behavioural model state
    bit          m_valid   = 0;
    bit          m_if      = 0;
    logic [31:0] m_addr    = '0;
    logic        m_we      = 1'b0;
    logic [3:0]  m_be      = '0;
    logic [31:0] m_wdata   = '0;
    bit          m_if_ack  = 0;
    bit          m_d_ack   = 0;
    bit          m_if_err  = 0;
    bit          m_d_err   = 0;
    logic [31:0] m_if_rd   = '0;
    logic [31:0] m_d_rd    = '0;
    int          m_starve  = 0;
    int          m_vcnt    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_mem();
        if (mem_valid) begin
            if (!mbusy) begin
                mbusy = 1;
                mwait = (mem_wait_cfg < 0) ? int'($urandom_range(0, 3)) : mem_wait_cfg;
            end
            if (mwait == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_data_fix ? mem_data_val : $urandom;
                mbusy     = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                mwait--;
            end
        end else begin
            mbusy     = 0;
            mem_ready = spurious_en && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
    endtask

    task automatic drive_reqs();
        dreq_t t;
        if (if_ack) if_req = 1'b0;
        if (!if_req && if_q.size() > 0) begin
            if_addr = if_q.pop_front();
            if_req  = 1'b1;
        end
        if (d_ack) d_req = 1'b0;
        if (!d_req && d_q.size() > 0) begin
            t       = d_q.pop_front();
            d_we    = t.we;
            d_be    = t.be;
            d_addr  = t.addr;
            d_wdata = t.wdata;
            d_req   = 1'b1;
        end
    endtask

    task automatic gen_random();
        dreq_t t;
        if (if_q.size() == 0 && $urandom_range(0, 3) == 0) if_q.push_back($urandom);
        if (d_q.size() == 0 && $urandom_range(0, 2) == 0) begin
            t.we    = 1'($urandom_range(0, 1));
            t.be    = 4'($urandom);
            t.addr  = $urandom;
            t.wdata = $urandom;
            d_q.push_back(t);
        end
    endtask

    // Compare DUT outputs with the model, then advance the model over the next edge.
    task automatic check_and_model();
        if (mem_valid) begin
            vcycles++;
            obs_addr  = mem_addr;
            obs_we    = mem_we;
            obs_be    = mem_be;
            obs_wdata = mem_wdata;
            if (mem_ready) hs_cycle = cyc;
        end
        if (if_ack || d_ack) begin
            ack_cycle = cyc;
            obs_err   = if_err | d_err;
        end
        if (if_ack) ack_log.push_back(1'b1);
        if (d_ack) ack_log.push_back(1'b0);

        chk("mem_valid", 32'(mem_valid), 32'(m_valid));
        if (m_valid) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_be", 32'(mem_be), 32'(m_be));
            if (!m_if) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ack", 32'(if_ack), 32'(m_if_ack));
        chk("d_ack", 32'(d_ack), 32'(m_d_ack));
        chk("if_err", 32'(if_err), 32'(m_if_err));
        chk("d_err", 32'(d_err), 32'(m_d_err));
        chk("if_rdata", if_rdata, m_if_rd);
        if (m_d_ack) chk("d_rdata", d_rdata, m_d_rd);

        if (rst) begin
            m_valid  = 0;
            m_if_ack = 0;
            m_d_ack  = 0;
            m_if_err = 0;
            m_d_err  = 0;
            m_if_rd  = '0;
            m_d_rd   = '0;
            m_starve = 0;
        end else if (m_if_ack || m_d_ack) begin
            m_if_ack = 0;
            m_d_ack  = 0;
            m_if_err = 0;
            m_d_err  = 0;
        end else if (m_valid) begin
            m_vcnt++;
            if (mem_ready) begin
                m_valid = 0;
                if (m_if) begin
                    m_if_ack = 1;
                    m_if_rd  = mem_rdata;
                end else begin
                    m_d_ack = 1;
                    m_d_rd  = mem_rdata;
                end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (m_vcnt == int'(TMO)) begin
                m_valid = 0;
                if (m_if) begin
                    m_if_ack = 1;
                    m_if_err = 1;
                    m_if_rd  = 32'h0000_0013;
                end else begin
                    m_d_ack = 1;
                    m_d_err = 1;
                    m_d_rd  = 32'h0;
                end
            end
`endif
        end else begin
            if (d_req && (!if_req || m_starve < int'(SMAX))) begin
                m_valid  = 1;
                m_if     = 0;
                m_vcnt   = 0;
                m_addr   = d_addr;
                m_we     = d_we;
                m_be     = d_be;
                m_wdata  = d_wdata;
                m_starve = if_req ? ((m_starve < int'(SMAX)) ? m_starve + 1 : m_starve) : 0;
            end else if (if_req) begin
                m_valid  = 1;
                m_if     = 1;
                m_vcnt   = 0;
                m_addr   = if_addr & 32'hFFFF_FFFC;
                m_we     = 1'b0;
                m_be     = 4'b1111;
                m_starve = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst = (rst_cycles > 0);
        if (rst_cycles > 0) rst_cycles--;
        if (rst) begin
            if_req = 1'b0;
            d_req  = 1'b0;
            if_q.delete();
            d_q.delete();
        end
        drive_mem();
        drive_reqs();
        if (rand_mode) gen_random();
        @(negedge clk);
        check_and_model();
    endtask

    task automatic run_until_acks(input string nm, input int n, input int budget);
        int start = ack_log.size();
        int c     = 0;
        while (ack_log.size() < start + n && c < budget) begin
            cycle();
            c++;
        end
        checks++;
        if (ack_log.size() < start + n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d acks, want %0d", nm, ack_log.size() - start, n);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        bit exp_order [12];
        dreq_t t;
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        rst_cycles = 2;
        repeat (3) cycle();

        chk("reset_mem_valid", 32'(mem_valid), 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_if_ack", 32'(if_ack), 32'h0);
        chk("reset_d_ack", 32'(d_ack), 32'h0);
        chk("reset_if_rdata", if_rdata, 32'h0);

        // Single fetch, zero memory wait
        mem_wait_cfg = 0; mem_data_fix = 1; mem_data_val = 32'h0010_0093;
        ack_log.delete(); vcycles = 0;
        if_q.push_back(32'h0000_0102);
        run_until_acks("fetch", 1, 20);
        repeat (2) cycle();
        chk("fetch_addr", obs_addr, 32'h0000_0100);
        chk("fetch_we", 32'(obs_we), 32'h0);
        chk("fetch_rdata", if_rdata, 32'h0010_0093);
        chk("fetch_ack_latency", 32'(ack_cycle - hs_cycle), 32'd1);
        chk("fetch_ack_count", 32'(ack_log.size()), 32'd1);
        chk("fetch_ack_kind", log_at(0), 32'd1);

        // Store with three wait cycles
        mem_wait_cfg = 3; ack_log.delete(); vcycles = 0;
        t.we = 1'b1; t.be = 4'b0011; t.addr = 32'h40; t.wdata = 32'hAABB_CCDD;
        d_q.push_back(t);
        run_until_acks("store", 1, 20);
        repeat (2) cycle();
        chk("store_valid_cycles", 32'(vcycles), 32'd4);
        chk("store_we", 32'(obs_we), 32'h1);
        chk("store_be", 32'(obs_be), 32'h3);
        chk("store_addr", obs_addr, 32'h40);
        chk("store_wdata", obs_wdata, 32'hAABB_CCDD);
        chk("store_ack_count", 32'(ack_log.size()), 32'd1);
        chk("store_ack_kind", log_at(0), 32'd0);

        // Collision: data first, then fetch
        mem_wait_cfg = -1; mem_data_fix = 0; ack_log.delete();
        t.we = 1'b0; t.be = 4'hF; t.addr = 32'h44; t.wdata = 32'h0;
        d_q.push_back(t);
        if_q.push_back(32'h0000_0200);
        run_until_acks("collision", 2, 40);
        repeat (2) cycle();
        chk("collision_count", 32'(ack_log.size()), 32'd2);
        chk("collision_first", log_at(0), 32'd0);
        chk("collision_second", log_at(1), 32'd1);

        // Starvation: continuous data traffic with a waiting fetch
        mem_wait_cfg = 0; ack_log.delete();
        for (int i = 0; i < 10; i++) begin
            t.we = 1'($urandom_range(0, 1)); t.be = 4'($urandom);
            t.addr = $urandom; t.wdata = $urandom;
            d_q.push_back(t);
        end
        if_q.push_back(32'h0000_0300);
        if_q.push_back(32'h0000_0304);
        run_until_acks("starve", 12, 100);
        for (int i = 0; i < 12; i++) chk($sformatf("starve_order_%0d", i), log_at(i), 32'(exp_order[i]));

        // Reset in the middle of a data access
        mem_wait_cfg = 20; ack_log.delete(); vcycles = 0;
        t.we = 1'b0; t.be = 4'hF; t.addr = 32'h80; t.wdata = 32'h0;
        d_q.push_back(t);
        for (int c = 0; c < 20 && vcycles < 2; c++) cycle();
        chk("rstmid_reached_mem", 32'(vcycles), 32'd2);
        rst_cycles = 1;
        cycle();
        cycle();
        chk("rstmid_valid_dropped", 32'(mem_valid), 32'h0);
        mem_wait_cfg = 0;
        repeat (5) cycle();
        chk("rstmid_no_ack", 32'(ack_log.size()), 32'd0);
        mem_data_fix = 1; mem_data_val = 32'h1234_5678;
        t.addr = 32'h84;
        d_q.push_back(t);
        run_until_acks("rstmid_after", 1, 20);
        chk("rstmid_after_kind", log_at(0), 32'd0);
        chk("rstmid_after_rdata", d_rdata, 32'h1234_5678);

`ifdef MEM_ARB_TIMEOUT_EN
        // Fetch that never gets mem_ready
        mem_wait_cfg = 100000; ack_log.delete(); vcycles = 0;
        if_q.push_back(32'h0000_0400);
        run_until_acks("timeout", 1, 40);
        chk("timeout_valid_cycles", 32'(vcycles), 32'(TMO));
        chk("timeout_err", 32'(obs_err), 32'h1);
        chk("timeout_rdata", if_rdata, 32'h0000_0013);
        cycle();
        chk("timeout_back_idle", 32'(if_ack), 32'h0);
`endif

        // Random traffic against the model
        mem_wait_cfg = -1; mem_data_fix = 0; spurious_en = 1; rand_mode = 1;
        ack_log.delete();
        repeat (3000) cycle();
        rand_mode = 0;
        repeat (40) cycle();
        checks++;
        if (ack_log.size() < 200) begin
            errors++;
            $display("FAIL random_progress: got %0d acks, want at least 200", ack_log.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
